regfile_wr_ctrl: RTL and testbench

- Write-port controller sitting directly upstream of an array of DEPTH×WIDTH `dff_en` storage cells.
- Accepts write requests over a valid/ready handshake, drives the shared data bus `D` and a one-hot `wr_en` vector into the storage array.
- Timing is arranged so each `dff_en` gated clock (NAND of `clk` and `wr_en`) stays glitch-free and captures exactly once per write.

---
 rtl/regfile_wr_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_regfile_wr_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_wr_ctrl
//
// Write-port controller for an array of DEPTH x WIDTH dff_en storage cells.
// Each storage row clocks through NAND(clk, wr_en[row]). The row therefore
// captures on the falling edge of clk that ends a clk-high phase during which
// its wr_en was held high.
//
// A request is accepted over valid/ready. The controller latches the address
// and data, and drives the data onto the shared bus D. It then raises exactly
// one wr_en bit for one negedge-to-negedge window.
//
// wr_en comes from a negedge register, so it only ever changes while clk is
// low. This keeps every gated row clock free of glitches.
//
// A write occupies IDLE (accept), ARM and HOLD, so a new request can be
// accepted every three cycles. With the optional VERIFY state it is every
// four cycles.
//
// Optional feature (macro WR_VERIFY_EN):
//   When defined, the controller adds a VERIFY state after HOLD. In VERIFY it
//   compares the word read back from the array (rd_q at rd_addr) with the
//   written data. On a mismatch it sets the sticky flag wr_err. Writes to an
//   out-of-range address skip the compare.
//
// Parameters:
//   WIDTH  data bits per word
//   DEPTH  number of storage rows (width of wr_en)
//   AW     address width, 2**AW >= DEPTH
//
// Ports:
//   clk        clock; the FSM and D update on posedge, wr_en on negedge
//   rst_n      asynchronous active-low reset
//   req_valid  write request present
//   req_ready  request can be accepted this cycle (IDLE and out of reset)
//   req_addr   target row
//   req_data   write data
//   D          shared data bus to all rows
//   wr_en      one-hot row write enable (all zero for out-of-range rows)
//   busy       write in progress (state != IDLE)
//   rd_addr    latched write address for read-back   (WR_VERIFY_EN only)
//   rd_q       read-back word from the array mux     (WR_VERIFY_EN only)
//   wr_err     sticky verify-mismatch flag           (WR_VERIFY_EN only)
// -----------------------------------------------------------------------------
module regfile_wr_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] D,
  output logic [DEPTH-1:0] wr_en,
  output logic             busy
`ifdef WR_VERIFY_EN
  ,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_q,
  output logic             wr_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_HOLD   = 2'd2
`ifdef WR_VERIFY_EN
    ,
    S_VERIFY = 2'd3
`endif
  } state_t;

  // DEPTH widened to AW+1 bits, so the range check is a same-width compare
  // even when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_live;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;
  logic [DEPTH-1:0] r_wr_en;
  logic [DEPTH-1:0] w_row_sel;
  logic             w_in_range;
  logic             w_accept;
  logic             w_ready;
  logic             w_busy;

  // r_live holds req_ready low during reset and releases it at the first
  // posedge after rst_n deasserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_ready = r_live;
        w_busy  = 1'b0;
        if (req_valid && r_live) begin
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
`ifdef WR_VERIFY_EN
        w_state_nxt = S_VERIFY;
`else
        w_state_nxt = S_IDLE;
`endif
      end
`ifdef WR_VERIFY_EN
      S_VERIFY: begin
        w_state_nxt = S_IDLE;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_busy      = 1'b0;
      end
    endcase
  end

  assign w_accept  = req_valid && w_ready;
  assign req_ready = w_ready;
  assign busy      = w_busy;

  // ---- posedge stage: FSM state, address/data latch, D bus ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // D must read 0 during reset, and the read-back address must be 0, so both
  // latches are cleared. Otherwise they only load on accept. This holds D
  // steady until the posedge after the capture negedge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_addr <= req_addr;
      r_data <= req_data;
    end
  end

  assign D = r_data;

  // Row decode. Addresses >= DEPTH match no row, and they are also masked
  // explicitly by w_in_range.
  always_comb begin
    w_row_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_addr == AW'(i)) begin
        w_row_sel[i] = 1'b1;
      end
    end
  end

  assign w_in_range = ({1'b0, r_addr} < DEPTH_C);

  // ---- negedge stage: row write enable ----
  // The ARM-cycle negedge raises the row's enable. The HOLD-cycle negedge
  // drops it, and that same falling edge is the row's capture edge. Because
  // the register is clocked by the falling edge, wr_en never moves while clk
  // is high.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= '0;
    end else if (r_state == S_ARM && w_in_range) begin
      r_wr_en <= w_row_sel;
    end else begin
      r_wr_en <= '0;
    end
  end

  assign wr_en = r_wr_en;

`ifdef WR_VERIFY_EN
  logic r_wr_err;

  // ---- verify stage: read-back compare, sticky until reset ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else if (r_state == S_VERIFY && w_in_range && (rd_q != r_data)) begin
      r_wr_err <= 1'b1;
    end
  end

  assign rd_addr = r_addr;
  assign wr_err  = r_wr_err;
`endif

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
module tb_regfile_wr_ctrl;

`ifdef WR_VERIFY_EN
  localparam int EXP_GAP = 4;
`else
  localparam int EXP_GAP = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  // DUT with DEPTH=8 (full address space)
  logic       req_valid, req_ready, busy;
  logic [2:0] req_addr;
  logic [7:0] req_data, D, wr_en;
  // DUT with DEPTH=6 (addresses 6,7 out of range)
  logic       v6, ready6, busy6;
  logic [2:0] a6;
  logic [7:0] d6, D6;
  logic [5:0] wr_en6;
`ifdef WR_VERIFY_EN
  logic [2:0] rd_addr, rd_addr6;
  logic [7:0] rd_q, rd_q6;
  logic       wr_err, wr_err6;
  logic       stuck = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int glitch_cnt = 0;
  int multi_cnt = 0;

  // Emulated storage arrays, fed only by the DUT outputs
  logic [7:0] mem  [8] = '{default: 8'h00};
  logic [7:0] mem6 [8] = '{default: 8'h00};
  logic [7:0] en_hi = '0;
  logic [5:0] en6_hi = '0;
  // Reference contents, derived from the requests that were issued
  logic [7:0] ref_mem  [8] = '{default: 8'h00};
  logic [7:0] ref_mem6 [8] = '{default: 8'h00};

  regfile_wr_ctrl #(.WIDTH(8), .DEPTH(8), .AW(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .D(D), .wr_en(wr_en), .busy(busy)
`ifdef WR_VERIFY_EN
    , .rd_addr(rd_addr), .rd_q(rd_q), .wr_err(wr_err)
`endif
  );

  regfile_wr_ctrl #(.WIDTH(8), .DEPTH(6), .AW(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(v6), .req_ready(ready6),
    .req_addr(a6), .req_data(d6), .D(D6), .wr_en(wr_en6), .busy(busy6)
`ifdef WR_VERIFY_EN
    , .rd_addr(rd_addr6), .rd_q(rd_q6), .wr_err(wr_err6)
`endif
  );

`ifdef WR_VERIFY_EN
  assign rd_q  = mem[rd_addr] & {7'h7f, ~stuck};
  assign rd_q6 = (rd_addr6 < 3'd6) ? mem6[rd_addr6] : 8'h00;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    en_hi  <= wr_en;
    en6_hi <= wr_en6;
  end

  // Row captures D on the falling edge that ends a clk-high phase with its
  // enable held high.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (en_hi[i]) mem[i] <= D;
    end
    for (int i = 0; i < 6; i++) begin
      if (en6_hi[i]) mem6[i] <= D6;
    end
  end

  always @(wr_en or wr_en6) begin
    if (clk === 1'b1 && rst_n === 1'b1) glitch_cnt++;
  end

  always @(negedge clk) begin
    #1;
    if ($countones(wr_en) > 1 || $countones(wr_en6) > 1) multi_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at the negedge+1 preceding the accept edge.
  task automatic wait_ready(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if ((sel ? ready6 : req_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(sel ? "accept_to6" : "accept_to", {31'd0, ok}, 32'd1);
  endtask

  int last_acc = 0;

  // Full-timing write on the DEPTH=8 DUT; starts and ends at posedge+1.
  task automatic write8(input logic [2:0] a, input logic [7:0] d, input bit hold);
    bit ok;
    logic [7:0] exp_en;
    exp_en = 8'd1 << a;
    req_addr = a;
    req_data = d;
    req_valid = 1'b1;
    wait_ready(1'b0, ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (!hold) req_valid = 1'b0;
    chk("arm_busy", {31'd0, busy}, 32'd1);
    chk("arm_ready", {31'd0, req_ready}, 32'd0);
    chk("arm_D", {24'd0, D}, {24'd0, d});
    chk("arm_wren_pre", {24'd0, wr_en}, 32'd0);
    @(negedge clk);
    #1;
    chk("arm_wren", {24'd0, wr_en}, {24'd0, exp_en});
    @(posedge clk);
    #1;
    chk("hold_wren", {24'd0, wr_en}, {24'd0, exp_en});
    chk("hold_D", {24'd0, D}, {24'd0, d});
    @(negedge clk);
    #1;
    chk("cap_wren", {24'd0, wr_en}, 32'd0);
    chk("cap_D", {24'd0, D}, {24'd0, d});
    ref_mem[a] = d;
    @(posedge clk);
    #1;
  endtask

  // Write on the DEPTH=6 DUT; starts and ends at posedge+1.
  task automatic write6(input logic [2:0] a, input logic [7:0] d);
    bit ok;
    logic [5:0] exp_en;
    exp_en = (a < 3'd6) ? (6'd1 << a) : 6'd0;
    a6 = a;
    d6 = d;
    v6 = 1'b1;
    wait_ready(1'b1, ok);
    if (!ok) begin
      v6 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    v6 = 1'b0;
    chk("w6_busy", {31'd0, busy6}, 32'd1);
    @(negedge clk);
    #1;
    chk("w6_arm_wren", {26'd0, wr_en6}, {26'd0, exp_en});
    @(posedge clk);
    #1;
    chk("w6_hold_wren", {26'd0, wr_en6}, {26'd0, exp_en});
    @(negedge clk);
    #1;
    chk("w6_cap_wren", {26'd0, wr_en6}, 32'd0);
    chk("w6_cap_D", {24'd0, D6}, {24'd0, d});
    if (a < 3'd6) ref_mem6[a] = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rows();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("row%0d", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("row6_%0d", i), {24'd0, mem6[i]}, {24'd0, ref_mem6[i]});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int prev;
    logic [2:0] ra;
    logic [7:0] rd;
    bit hold;
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_data = '0;
    v6 = 1'b0; a6 = '0; d6 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wren", {24'd0, wr_en}, 32'd0);
    chk("rst_D", {24'd0, D}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef WR_VERIFY_EN
    chk("rst_rdaddr", {29'd0, rd_addr}, 32'd0);
    chk("rst_err", {31'd0, wr_err}, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rel_ready_pre", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready", {31'd0, req_ready}, 32'd1);

    // Single write addr 3
    write8(3'd3, 8'hA5, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk_rows();

    // Back-to-back, valid held high
    for (int i = 0; i < 8; i++) begin
      prev = last_acc;
      write8(3'(i), 8'(i * 8'h11), 1'b1);
      if (i > 0) chk("b2b_gap", last_acc - prev, EXP_GAP);
    end
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk_rows();

    // DEPTH=6: in-range write, then out-of-range writes
    write6(3'd5, 8'h3C);
    write6(3'd7, 8'hFF);
    write6(3'd6, 8'hEE);
    repeat (2) begin @(posedge clk); #1; end
    chk_rows();
`ifdef WR_VERIFY_EN
    chk("err6_oor", {31'd0, wr_err6}, 32'd0);
`endif

    // Randomized traffic on both DUTs
    for (int i = 0; i < 30; i++) begin
      ra = 3'($urandom_range(0, 7));
      rd = 8'($urandom_range(0, 255));
      hold = ($urandom_range(0, 1) == 1);
      write8(ra, rd, hold);
      if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      write6(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
    repeat (2) begin @(posedge clk); #1; end
    chk_rows();

`ifdef WR_VERIFY_EN
    chk("err_clean", {31'd0, wr_err}, 32'd0);
    stuck = 1'b1;
    write8(3'd1, 8'h01, 1'b0);
    chk("err_pre", {31'd0, wr_err}, 32'd0);
    @(posedge clk);
    #1;
    chk("err_set", {31'd0, wr_err}, 32'd1);
    stuck = 1'b0;
    write8(3'd4, 8'h44, 1'b0);
    @(posedge clk);
    #1;
    chk("err_sticky", {31'd0, wr_err}, 32'd1);
`endif

    // Reset while in ARM after wr_en[2] rises
    req_addr = 3'd2;
    req_data = 8'h5A;
    req_valid = 1'b1;
    wait_ready(1'b0, ok);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_arm_wren", {24'd0, wr_en}, 32'h04);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_wren", {24'd0, wr_en}, 32'd0);
    chk("midrst_D", {24'd0, D}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
`ifdef WR_VERIFY_EN
    chk("midrst_err", {31'd0, wr_err}, 32'd0);
`endif
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_rel_busy", {31'd0, busy}, 32'd0);
    // Row 2 is undefined after the aborted write; rewrite it
    write8(3'd2, 8'h5A, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk_rows();

    chk("glitch", glitch_cnt, 0);
    chk("multihot", multi_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
